// File: rtl/hsv_core_commit_redirect_if.sv
// Commit-stage types and the commit/redirect handshake interface.
//
// hsv_core_commit_pkg : commit_data_t entry produced by the branch/jump
//                       execute stage (action, common.pc, next_pc).
// hsv_core_commit_redirect_if :
//   valid_i          commit entry valid, from execute stage
//   in               commit entry payload
//   stall_o          back-pressure to the execute stage
//   redirect_valid_o fetch redirect request
//   redirect_pc_o    fetch redirect target
//   redirect_ready_i fetch accepts the redirect
//   modport slave  : commit/redirect block side
//   modport master : execute/fetch side
package hsv_core_commit_pkg;

   typedef enum logic [1:0] {
      COMMIT_NEXT      = 2'd0,
      COMMIT_JUMP      = 2'd1,
      COMMIT_EXCEPTION = 2'd2
   } commit_action_t;

   typedef struct packed {
      logic [31:0] pc;
   } commit_common_t;

   typedef struct packed {
      commit_action_t action;
      commit_common_t common;
      logic [31:0]    next_pc;
   } commit_data_t;

endpackage

interface hsv_core_commit_redirect_if;
   import hsv_core_commit_pkg::*;

   logic         valid_i;
   commit_data_t in;
   logic         stall_o;
   logic         redirect_valid_o;
   logic [31:0]  redirect_pc_o;
   logic         redirect_ready_i;

   modport slave (
      input  valid_i, in, redirect_ready_i,
      output stall_o, redirect_valid_o, redirect_pc_o
   );

   modport master (
      output valid_i, in, redirect_ready_i,
      input  stall_o, redirect_valid_o, redirect_pc_o
   );

endinterface

// File: rtl/hsv_core_commit_redirect.sv
// Commit / control-flow redirect stage.
//
// Retires in-order commit entries from the branch/jump execute stage. A
// mispredicted jump or an exception flushes the pipeline for FLUSH_CYCLES
// cycles and then hands a redirect target to fetch, holding it until fetch
// accepts. The execute stage is stalled for the whole sequence.
//
// Ports:
//   clk_core            core clock, rising edge
//   rst_core            asynchronous active-high reset
//   bus (slave)         valid_i/in commit entry, stall_o,
//                       redirect_valid_o/redirect_pc_o/redirect_ready_i
//   flush_req_o         pipeline flush request
//   retire_o            one-cycle pulse per retired instruction
//   trap_o              one-cycle trap pulse
//   trap_epc_o          pc of the trapping instruction, valid with trap_o
//   mispredict_count_o  number of COMMIT_JUMP entries accepted (wraps)
module hsv_core_commit_redirect #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                       clk_core,
   input  logic                       rst_core,
   hsv_core_commit_redirect_if.slave  bus,
   output logic                       flush_req_o,
   output logic                       retire_o,
   output logic                       trap_o,
   output logic [31:0]                trap_epc_o,
   output logic [CNT_W-1:0]           mispredict_count_o
);
   import hsv_core_commit_pkg::*;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH    = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [3:0]         flush_cnt, flush_cnt_n;
   logic               flush_n, redirect_valid, redirect_valid_n;
   logic               retire_n, trap_n;
   logic [31:0]        redirect_pc, redirect_pc_n, trap_epc_n;
   logic [CNT_W-1:0]   count_n;

   // Stall depends on the state flop only, never on the inputs.
   assign bus.stall_o          = (state != IDLE);
   assign bus.redirect_valid_o = redirect_valid;
   assign bus.redirect_pc_o    = redirect_pc;

   always_ff @(posedge clk_core or posedge rst_core) begin
      if (rst_core) begin
         state              <= IDLE;
         flush_cnt          <= '0;
         flush_req_o        <= 1'b0;
         redirect_valid     <= 1'b0;
         redirect_pc        <= '0;
         retire_o           <= 1'b0;
         trap_o             <= 1'b0;
         trap_epc_o         <= '0;
         mispredict_count_o <= '0;
      end else begin
         state              <= state_n;
         flush_cnt          <= flush_cnt_n;
         flush_req_o        <= flush_n;
         redirect_valid     <= redirect_valid_n;
         redirect_pc        <= redirect_pc_n;
         retire_o           <= retire_n;
         trap_o             <= trap_n;
         trap_epc_o         <= trap_epc_n;
         mispredict_count_o <= count_n;
      end
   end

   always_comb begin
      state_n          = state;
      flush_cnt_n      = flush_cnt;
      flush_n          = flush_req_o;
      redirect_valid_n = redirect_valid;
      redirect_pc_n    = redirect_pc;
      retire_n         = 1'b0;
      trap_n           = 1'b0;
      trap_epc_n       = trap_epc_o;
      count_n          = mispredict_count_o;

      unique case (state)
         IDLE: begin
            if (bus.valid_i) begin
               unique case (bus.in.action)
                  COMMIT_JUMP: begin
                     retire_n      = 1'b1;
                     redirect_pc_n = bus.in.next_pc;
                     count_n       = mispredict_count_o + 1'b1;
                     flush_cnt_n   = FLUSH_LOAD;
                     flush_n       = 1'b1;
                     state_n       = FLUSH;
                  end
                  COMMIT_EXCEPTION: begin
                     trap_n        = 1'b1;
                     trap_epc_n    = bus.in.common.pc;
                     redirect_pc_n = TRAP_VECTOR;
                     flush_cnt_n   = FLUSH_LOAD;
                     flush_n       = 1'b1;
                     state_n       = FLUSH;
                  end
                  default: retire_n = 1'b1;
               endcase
            end
         end
         FLUSH: begin
            // Counter is loaded with FLUSH_CYCLES-1, so flush stays high
            // for exactly FLUSH_CYCLES cycles before the redirect is raised.
            if (flush_cnt == '0) begin
               flush_n          = 1'b0;
               redirect_valid_n = 1'b1;
               state_n          = REDIRECT;
            end else begin
               flush_cnt_n = flush_cnt - 1'b1;
            end
         end
         REDIRECT: begin
            if (bus.redirect_ready_i) begin
               redirect_valid_n = 1'b0;
               state_n          = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: doc/hsv_core_commit_redirect.md
Name: hsv_core_commit_redirect

Overview:
- Sits directly downstream of the branch/jump execute stage and consumes its registered valid/commit_data_t output.
- Retires in-order results and resolves control-flow outcomes:
  - COMMIT_JUMP (mispredict): flushes the pipeline, then redirects fetch to out.next_pc.
  - COMMIT_EXCEPTION: flushes, reports the trap, then redirects fetch to a trap vector.
- Back-pressures the execute stage through its stall input while a redirect sequence is in progress.

Parameters:
- FLUSH_CYCLES, 2, number of consecutive cycles flush_req_o is held high per redirect; legal range 1..15.
- TRAP_VECTOR, 32'h0000_0100, fetch address used on COMMIT_EXCEPTION.
- CNT_W, 32, width of the mispredict counter.

Ports:
- clk_core  input  1  core clock; all state updates on its rising edge.
- rst_core  input  1  asynchronous, active-high reset.
- valid_i  input  1  commit entry valid (from execute stage valid_o).
- in  input  commit_data_t  commit entry; uses action, common.pc, next_pc.
- stall_o  output  1  stall to execute stage; high whenever state != IDLE.
- flush_req_o  output  1  pipeline flush request.
- redirect_valid_o  output  1  fetch redirect request.
- redirect_pc_o  output  32  fetch redirect target.
- redirect_ready_i  input  1  fetch accepts redirect.
- retire_o  output  1  one-cycle pulse per retired instruction.
- trap_o  output  1  one-cycle trap pulse.
- trap_epc_o  output  32  pc of the trapping instruction; valid with trap_o.
- mispredict_count_o  output  CNT_W  count of COMMIT_JUMP entries accepted.

Behaviour:
- Reset (async assert, sync release) forces:
  - state = IDLE;
  - all 1-bit outputs low;
  - redirect_pc_o = 0, trap_epc_o = 0, mispredict_count_o = 0, flush counter = 0.
- Reset asserted mid-sequence abandons the sequence immediately; there is no post-reset redirect.
- Encoding and output structure:
  - FSM states: IDLE, FLUSH, REDIRECT.
  - All outputs are registered, except stall_o, which is decoded from the state flop only and has no input dependence.
- IDLE, entry accepted only when valid_i = 1:
  - COMMIT_NEXT, or any other non-JUMP/non-EXCEPTION encoding: retire_o = 1 next cycle; stay in IDLE.
  - COMMIT_JUMP, all effective next cycle:
    - retire_o = 1; redirect_pc_o = in.next_pc;
    - mispredict_count_o += 1 (wraps at 2^CNT_W);
    - flush counter = FLUSH_CYCLES-1; flush_req_o = 1; state = FLUSH.
  - COMMIT_EXCEPTION, effective next cycle:
    - no retire; trap_o = 1; trap_epc_o = in.common.pc;
    - redirect_pc_o = TRAP_VECTOR; flush counter = FLUSH_CYCLES-1; flush_req_o = 1; state = FLUSH.
- FLUSH:
  - flush_req_o stays high while counter > 0; counter decrements each cycle.
  - When the counter is 0: flush_req_o drops, redirect_valid_o rises, state = REDIRECT.
  - flush_req_o is therefore high for exactly FLUSH_CYCLES cycles.
- REDIRECT:
  - redirect_valid_o = 1 and redirect_pc_o is held stable until redirect_ready_i is sampled high.
  - On that edge: redirect_valid_o = 0, state = IDLE.
  - redirect_ready_i is ignored outside REDIRECT.
- Input outside IDLE: valid_i and in are ignored, with no retire, no count and no trap. Upstream is stalled or flushed during these states.
- Stall timing: stall_o goes high the cycle after a JUMP/EXCEPTION is accepted and falls the cycle after the redirect handshake.
- Minimum sequence for a JUMP/EXCEPTION with redirect_ready_i tied high: FLUSH_CYCLES + 1 cycles from acceptance to the return to IDLE.
- retire_o and trap_o are never high in the same cycle.

Test Plan:
- Reset, then 3 back-to-back COMMIT_NEXT entries -> retire_o high for 3 consecutive cycles, each 1 cycle after its input; flush_req_o and stall_o stay 0.
- COMMIT_JUMP with next_pc = 32'h0000_2040, FLUSH_CYCLES = 2, ready high -> retire_o pulses; flush_req_o high for 2 cycles; then redirect_valid_o high for 1 cycle with redirect_pc_o = 32'h2040; mispredict_count_o = 1; stall_o high for 3 cycles.
- COMMIT_EXCEPTION with common.pc = 32'h0000_1004 -> trap_o pulse with trap_epc_o = 32'h1004; redirect_pc_o = 32'h100; no retire_o; count unchanged.
- JUMP with redirect_ready_i held low for 5 cycles -> redirect_valid_o stays high with a stable pc; valid_i COMMIT_NEXT entries driven during FLUSH/REDIRECT produce no retire_o.
- Assert rst_core while in FLUSH -> all outputs 0 immediately (asynchronous); the next entry after release is handled from IDLE.
- Preload count to 2^CNT_W-1 (CNT_W = 4: 15 jumps), then one more JUMP -> mispredict_count_o wraps to 0.
